// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response bus: req/gnt issue handshake and an in-order rvalid return.
interface fetch_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage with a DEPTH-entry prefetch queue between instruction memory and the IF/ID register.
// At most one memory request is outstanding; a response in flight across a redirect is dropped.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [XLEN-1:0]       PCTargetE,
  fetch_prefetch_unit_if.master imem,
  output logic [31:0]           InstrD,
  output logic [XLEN-1:0]       PCD,
  output logic [XLEN-1:0]       PCPlus4D,
  output logic                  ValidD,
  output logic [XLEN-1:0]       PCF_out
);
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] req_pc_q;
  logic            outstanding_q, outstanding_d;
  logic            discard_q, discard_d;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     instr_d_q;
  logic [XLEN-1:0] pc_d_q;
  logic            valid_d_q;
  logic            issue, fire, resp, push, pop, empty;

  always_comb begin
    empty = (count_q == '0);
    // Issue only with nothing outstanding, so a granted request always has a free slot.
    issue = !rst && !StallF && !PCSrcE && !outstanding_q && (count_q < CntFull);
    fire  = issue && imem.gnt;
    resp  = imem.rvalid && outstanding_q;
    push  = resp && !discard_q && !PCSrcE;
    pop   = !PCSrcE && !FlushD && !StallD && !empty;
  end

  always_comb begin
    pcf_d         = pcf_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    if (PCSrcE) begin
      pcf_d = {PCTargetE[XLEN-1:2], 2'b00};
    end else if (fire) begin
      pcf_d = pcf_q + XLEN'(4);
    end
    if (fire) begin
      outstanding_d = 1'b1;
    end else if (resp) begin
      outstanding_d = 1'b0;
    end
    // A redirect with a response still pending marks that response as stale.
    if (resp) begin
      discard_d = 1'b0;
    end else if (PCSrcE && outstanding_q) begin
      discard_d = 1'b1;
    end
    if (PCSrcE) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q         <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pcf_q         <= pcf_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      if (fire) begin
        req_pc_q <= pcf_q;
      end
      if (PCSrcE) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_pc[wr_ptr_q]    <= req_pc_q;
      q_instr[wr_ptr_q] <= imem.rdata;
    end
  end

  // D loads from the pre-edge queue head, so a same-cycle push into an empty queue is a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d_q <= NOP_INSTR;
      pc_d_q    <= RESET_PC;
      valid_d_q <= 1'b0;
    end else if (PCSrcE || FlushD) begin
      instr_d_q <= NOP_INSTR;
      valid_d_q <= 1'b0;
    end else if (!StallD) begin
      if (!empty) begin
        instr_d_q <= q_instr[rd_ptr_q];
        pc_d_q    <= q_pc[rd_ptr_q];
        valid_d_q <= 1'b1;
      end else begin
        instr_d_q <= NOP_INSTR;
        valid_d_q <= 1'b0;
      end
    end
  end

  assign imem.req  = issue;
  assign imem.addr = pcf_q;
  assign InstrD    = instr_d_q;
  assign PCD       = pc_d_q;
  assign PCPlus4D  = pc_d_q + XLEN'(4);
  assign ValidD    = valid_d_q;
  assign PCF_out   = pcf_q;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: random memory latency/grants and pipeline controls, with a
// program-order scoreboard of expected fetched instructions checked as they reach IF/ID.
module tb_fetch_prefetch_unit;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] RPC   = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D, PCF_out;
  logic        ValidD;

  fetch_prefetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_prefetch_unit #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(bus), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .PCF_out(PCF_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int gnt_pct = 100;
  int lat_max = 0;
  bit spurious = 1'b0;
  logic [63:0] exp_q[$];  // {pc, instr} granted in program order, not yet seen in D

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction memory: one request at a time, response 1..lat_max+1 cycles after grant.
  logic mem_pending = 1'b0;
  int   mem_wait = 0;
  logic [31:0] mem_addr = '0;
  initial begin
    logic fire_n, resp_n;
    logic [31:0] addr_n;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(negedge clk);
      fire_n = bus.req && bus.gnt;
      addr_n = bus.addr;
      resp_n = bus.rvalid;
      @(posedge clk);
      #1;
      if (resp_n) begin
        bus.rvalid = 1'b0;
        mem_pending = 1'b0;
      end
      if (fire_n) begin
        mem_pending = 1'b1;
        mem_wait = int'($urandom_range(lat_max, 0));
        mem_addr = addr_n;
      end
      bus.rdata = $urandom;
      if (mem_pending && !bus.rvalid) begin
        if (mem_wait == 0) begin
          bus.rvalid = 1'b1;
          bus.rdata = mem_word(mem_addr);
        end else begin
          mem_wait--;
        end
      end else if (!mem_pending && spurious && $urandom_range(99, 0) < 5) begin
        bus.rvalid = 1'b1;  // stray response with nothing outstanding
      end
      bus.gnt = ($urandom_range(99, 0) < gnt_pct);
    end
  end

  // Monitor: evaluates the effect of each edge from the inputs sampled before it.
  initial begin
    logic p_rst = 1'b0, p_sd = 1'b0, p_fl = 1'b0, p_pc = 1'b0, p_fire = 1'b0, p_rv = 1'b0;
    logic [31:0] p_tgt = '0, p_addr = '0;
    int   p_cnt = 0;
    bit   have_prev = 1'b0, out = 1'b0, live = 1'b0, m_valid = 1'b0, m_pc_known = 1'b0;
    logic [31:0] m_pc = RPC, m_instr = NOP, fpc = RPC;
    logic [63:0] e;
    logic exp_req;
    forever begin
      @(negedge clk);
      if (have_prev) begin
        if (p_rst) begin
          check("rst_valid", ValidD, 0);
          check("rst_instr", InstrD, NOP);
          check("rst_pcd", PCD, RPC);
          exp_q.delete();
          out = 0; live = 0; fpc = RPC;
          m_valid = 0; m_instr = NOP; m_pc = RPC; m_pc_known = 1;
        end else begin
          if (p_pc || p_fl) begin
            check("flush_valid", ValidD, 0);
            check("flush_instr", InstrD, NOP);
            m_valid = 0; m_instr = NOP; m_pc_known = 0;
          end else if (p_sd) begin
            check("hold_valid", ValidD, m_valid);
            check("hold_instr", InstrD, m_instr);
            if (m_pc_known) check("hold_pcd", PCD, m_pc);
          end else begin
            check("load_valid", ValidD, (p_cnt > 0));
            if (p_cnt > 0) begin
              e = exp_q.pop_front();
              check("load_pcd", PCD, e[63:32]);
              check("load_instr", InstrD, e[31:0]);
              check("load_pcplus4", PCPlus4D, e[63:32] + 32'd4);
              m_valid = 1; m_pc = e[63:32]; m_instr = e[31:0]; m_pc_known = 1;
            end else begin
              check("bubble_instr", InstrD, NOP);
              if (m_pc_known) check("bubble_pcd", PCD, m_pc);
              m_valid = 0; m_instr = NOP;
            end
          end
          if (p_rv && out) begin
            out = 0; live = 0;
          end
          if (p_pc) begin
            exp_q.delete();
            live = 0;
            fpc = {p_tgt[31:2], 2'b00};
          end
          if (p_fire) begin
            check("fetch_addr", p_addr, fpc);
            exp_q.push_back({fpc, mem_word(fpc)});
            out = 1; live = 1;
            fpc = fpc + 32'd4;
          end
        end
        check("pcf", PCF_out, fpc);
      end
      p_cnt = exp_q.size() - (live ? 1 : 0);
      exp_req = !rst && !StallF && !PCSrcE && !out && (p_cnt < int'(DEPTH));
      check("imem_req", bus.req, exp_req);
      p_rst = rst; p_sd = StallD; p_fl = FlushD; p_pc = PCSrcE; p_tgt = PCTargetE;
      p_fire = bus.req && bus.gnt; p_addr = bus.addr; p_rv = bus.rvalid;
      have_prev = 1'b1;
    end
  end

  task automatic run(input logic sf, input logic sd, input logic fl, input logic pc,
                     input logic [31:0] tgt, input int n);
    StallF = sf; StallD = sd; FlushD = fl; PCSrcE = pc; PCTargetE = tgt;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    run(0, 0, 0, 0, 32'h0, 3);
    rst = 1'b0;
    run(0, 0, 0, 0, 32'h0, 12);          // latency-1 free run
    run(0, 1, 0, 0, 32'h0, 10);          // D stalled: queue fills, issue stops
    run(0, 0, 0, 0, 32'h0, 8);
    lat_max = 2;
    run(0, 0, 0, 0, 32'h0, 3);
    run(0, 0, 0, 1, 32'h103, 1);         // redirect, likely with a request in flight
    run(0, 0, 0, 0, 32'h0, 10);
    run(0, 1, 1, 0, 32'h0, 1);           // flush while stalled
    run(0, 0, 0, 0, 32'h0, 6);
    run(1, 0, 0, 0, 32'h0, 5);           // fetch stalled, D drains
    run(0, 0, 0, 0, 32'h0, 6);
    lat_max = 0;
    run(0, 0, 0, 1, 32'hFFFF_FFF4, 1);   // fetch across the top of the address space
    run(0, 0, 0, 0, 32'h0, 14);
    gnt_pct = 70; lat_max = 3; spurious = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      StallF    = ($urandom_range(99, 0) < 20);
      StallD    = ($urandom_range(99, 0) < 25);
      FlushD    = ($urandom_range(99, 0) < 5);
      PCSrcE    = ($urandom_range(99, 0) < 4);
      PCTargetE = ($urandom_range(99, 0) < 10) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      @(posedge clk);
      #1;
    end
    spurious = 1'b0;
    run(1, 0, 0, 0, 32'h0, DEPTH + 10);  // fetch stalled: everything granted must drain
    @(negedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-register fetch stage.
- Generates the fetch PC and issues requests to instruction memory with a req/gnt/rvalid handshake. Memory latency is variable, with at most one request outstanding.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, and drives the IF/ID register from the queue head.
- Supports stall, decode flush and execute-stage redirect, and discards stale in-flight responses after a redirect.

Parameters:
- XLEN, 32, PC/address width (≥32).
- DEPTH, 4, prefetch queue entries (power of 2, ≥2).
- RESET_PC, 0, fetch PC after reset (word aligned).
- NOP_INSTR, 32'h00000013, instruction presented when ValidD=0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- StallF  in  1  block new memory requests; queue keeps accepting responses.
- StallD  in  1  hold the IF/ID register; no queue pop.
- FlushD  in  1  invalidate the IF/ID register.
- PCSrcE  in  1  redirect request.
- PCTargetE  in  XLEN  redirect target.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  request address (current fetch PC).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid (in order, at most one outstanding).
- imem_rdata  in  32  response instruction.
- InstrD  out  32  IF/ID instruction.
- PCD  out  XLEN  IF/ID PC.
- PCPlus4D  out  XLEN  PCD+4, modulo 2^XLEN.
- ValidD  out  1  IF/ID holds a real instruction.
- PCF_out  out  XLEN  current fetch PC (debug/hazard use).

Behaviour:
- Reset, on the rising edge with rst=1:
  - fetch PC = RESET_PC; queue empty; outstanding=0; discard=0.
  - InstrD=NOP_INSTR, PCD=RESET_PC, ValidD=0.
  - imem_req=0 while rst is high.
  - Reset overrides every other input in the same cycle.
- Issue:
  - imem_req = !rst & !StallF & !PCSrcE & !outstanding & (count < DEPTH).
  - Slot reservation: count plus the outstanding request never exceeds DEPTH. Because issue requires outstanding=0, a grant never overfills the queue.
  - On req & gnt: latch req_pc = fetch PC, set outstanding=1, fetch PC += 4 (wraps modulo 2^XLEN).
- Response, on imem_rvalid with outstanding=1:
  - Clear outstanding.
  - If discard=0: push {req_pc, imem_rdata} at tail. If discard=1: drop the data and clear discard.
  - rvalid while outstanding=0 is ignored.
- IF/ID register update, in priority order:
  - a) PCSrcE=1, or FlushD=1: ValidD<=0, InstrD<=NOP_INSTR, no pop.
  - b) StallD=1: hold all D outputs, no pop.
  - c) Queue non-empty: load head {PC, instr}, ValidD<=1, pop.
  - d) Queue empty: ValidD<=0, InstrD<=NOP_INSTR; PCD holds.
- Latency:
  - rvalid in cycle t → entry in queue in cycle t+1.
  - With the queue empty and no stall, ValidD=1 with that instruction in cycle t+2.
- Redirect (PCSrcE=1), effective on that edge:
  - fetch PC <= {PCTargetE[XLEN-1:2], 2'b00}; queue cleared (count=0); D invalidated as in a).
  - If a request is outstanding and rvalid is not asserted this cycle, set discard=1.
  - If rvalid is asserted this cycle, the response is dropped and outstanding cleared.
  - Next possible request is in cycle t+1, to the target address.
- Simultaneous push and pop with a non-empty queue: count unchanged. Push into an empty queue plus a D load in the same cycle: D loads from the pre-edge state (empty → bubble); the pushed entry loads next cycle.
- Full queue (count=DEPTH): imem_req=0; pops resume issue the next cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- StallF alone does not block pops or responses; StallD alone does not block issue up to full.

Test Plan:
- Reset then free-running, imem latency 1 (gnt=1, rvalid the cycle after grant) → imem_addr 0,4,8,...; ValidD first high with PCD=0, PCPlus4D=4; thereafter consecutive PCs.
- StallD held 10 cycles, DEPTH=4 → exactly 4 entries buffered after the instruction in D, imem_req=0 while full; on release PCD = 4,8,12,16 in 4 consecutive cycles, no gaps and no duplicates.
- Redirect to 0x103 while a request to 0x20 is outstanding (rvalid 2 cycles later) → the 0x20 data never reaches D; next imem_addr=0x100; first valid PCD=0x100.
- FlushD with StallD both high for one cycle → ValidD=0, InstrD=0x00000013, queue count unchanged; next unstalled cycle loads the previous head.
- StallF high 5 cycles with a non-empty queue → imem_req=0; D keeps draining until empty, then ValidD=0; resume from the held fetch PC.
- Fetch PC at 0xFFFFFFFC with XLEN=32 → next imem_addr=0x00000000; PCPlus4D for that entry = 0x00000000.
